// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed-latency busy window
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op,
    input  logic        md_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hilo_rdata
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_wr;

    logic        is_md;
    logic        is_mul;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_sgn;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign is_md      = (md_op >= 3'd1) && (md_op <= 3'd4);
    assign is_mul     = (md_op == 3'd1) || (md_op == 3'd2);
    assign start      = md_valid && is_md && (state == IDLE);
    assign hilo_rdata = mf_sel ? hi : lo;

    // Signed product via sign-extended 64-bit operands; the low 64 bits are exact.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide runs on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        div_sgn = (md_op == 3'd3);
        div_a   = (div_sgn && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        div_b   = (div_sgn && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        if (div_b == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = div_a / div_b;
            ur = div_a % div_b;
        end
        quo = (div_sgn && (rs_val[31] ^ rt_val[31])) ? (32'd0 - uq) : uq;
        rem = (div_sgn && rs_val[31]) ? (32'd0 - ur) : ur;
    end

    always_comb begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (rt_val != 32'd0);
        case (md_op)
            3'd1: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            3'd2: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending_hi <= res_hi;
                        pending_lo <= res_lo;
                        pending_wr <= res_wr;
                        cnt        <= is_mul ? MULT_CNT : DIV_CNT;
                        state      <= is_mul ? MUL : DIV;
                        busy       <= 1'b1;
                    end else if (md_valid && (md_op == 3'd5)) begin
                        hi <= rs_val;
                    end else if (md_valid && (md_op == 3'd6)) begin
                        lo <= rs_val;
                    end
                end
                MUL, DIV: begin
                    if (cnt == 4'd1) begin
                        // Divide-by-zero clears pending_wr, leaving HI/LO untouched.
                        if (pending_wr) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        cnt   <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline. Owns the HI/LO registers.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and services mthi/mtlo writes and mfhi/mflo reads.
- Produces the busy and start indications that the D-stage stall logic uses to hold md/mf/mt instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- md_valid  in  1  E-stage instruction is real (low on bubbles)
- rs_val  in  32  forwarded rs operand (E stage)
- rt_val  in  32  forwarded rt operand (E stage)
- mf_sel  in  1  0 = read LO, 1 = read HI (mfhi/mflo in E)
- start  out  1  combinational: md_valid & md_op in 1..4 & state==IDLE
- busy  out  1  registered: high while an operation is in flight
- hilo_rdata  out  32  combinational: mf_sel ? HI : LO

Behaviour:
- Reset (asynchronous, reset_n low): HI=0, LO=0, state=IDLE, cnt=0, busy=0. start and hilo_rdata follow from these immediately.
- Reset asserted mid-operation aborts it. No HI/LO update occurs.
- States: IDLE, MUL, DIV.
- IDLE:
  - On start, latch the operation's result into pending_hi/pending_lo, computed from rs_val/rt_val in that same cycle.
  - Load cnt = MULT_CYCLES or DIV_CYCLES and go to MUL or DIV.
- MUL / DIV:
  - busy=1; cnt decrements each clock.
  - On the edge where cnt==1: HI<=pending_hi, LO<=pending_lo, state<=IDLE, busy<=0.
- Timing: start high in cycle T gives busy high in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO readable with new values from T+N+1, when busy is also 0.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned product.
- div (signed):
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (rt_val==0): the operation still occupies DIV_CYCLES with busy high. HI/LO are left unchanged at completion.
- mthi/mtlo:
  - Accepted only when md_valid and state==IDLE. HI (or LO) <= rs_val at the clock edge; no busy.
  - Issued while busy: ignored. This is a protocol violation, since the stall logic guarantees it cannot occur; the bench flags it.
- md_op 1..4 while busy: ignored; start stays 0. Same bench flag.
- md_valid=0: no state change regardless of md_op.
- hilo_rdata always reflects the committed HI/LO, never the pending values.
- Pipeline flush does not exist in P6. An issued operation always completes.
- Stall-side contract: the D stage stalls an md/mf/mt instruction while (busy | start). This block relies on that and adds no internal queueing.

Test Plan:
- Reset: drive reset_n low asynchronously between edges -> HI=LO=0, busy=0 immediately. Assert reset_n=0 in the 3rd busy cycle of a mult -> busy drops at once and HI/LO stay 0.
- mult timing: rs=0xFFFFFFFE (-2), rt=3 -> start=1 in cycle T; busy=1 for exactly T+1..T+5; from T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div signs:
  - rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 10 busy cycles.
  - divu rs=7, rt=2 -> LO=3, HI=1.
  - rs=0x80000000, rt=0xFFFFFFFF (div) -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x1234 and LO=0x5678 via mthi/mtlo, then div with rt=0 -> busy for 10 cycles; HI/LO remain 0x1234/0x5678.
- Back-to-back issue:
  - mult at T, then mult held until T+6 -> second start accepted in T+6. A start attempted at T+3 is ignored (start=0, flag raised).
  - mtlo 0xABCD in an idle cycle -> hilo_rdata with mf_sel=0 shows 0xABCD in the next cycle.
- Bubbles: md_op=1 with md_valid=0 -> start=0, busy stays 0, HI/LO unchanged.
